dm_store_packer: RTL and testbench

//  Store-side counterpart of the immediate/load extenders: narrows a 32-bit register value to

---
 rtl/dm_store_packer.sv | 136 +++++++++++++
 tb/tb_dm_store_packer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_store_packer.sv
// dm_store_packer: narrows a 32-bit store value to byte/half/word, places it on
// the correct lanes of the word-wide data-memory bus with byte enables, and
// buffers it in a DEPTH-entry FIFO in front of a valid/ready memory port.
//
// Optional feature macro: STORE_ALIGN_CHECK_EN
//   When defined, misaligned SW/SH are accepted but dropped, and align_err
//   pulses for exactly one cycle afterwards. When undefined, the align_err
//   port does not exist and unused low address bits are ignored.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          store request handshake
//   in_op                      0=SW 1=SH 2=SB 3=reserved (accepted, discarded)
//   in_addr, in_data           byte address, register value
//   mem_valid/mem_ready        head-of-buffer handshake towards memory
//   mem_addr, mem_wdata, mem_be  word address, lane data, byte enables
//   pending                    number of occupied entries
//   align_err                  (STORE_ALIGN_CHECK_EN) misalignment pulse
module dm_store_packer #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [31:0]              in_addr,
  input  logic [31:0]              in_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic [$clog2(DEPTH):0]   pending
`ifdef STORE_ALIGN_CHECK_EN
  ,
  output logic                     align_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [29:0] q_addr [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [3:0]  q_be   [DEPTH];

  logic [AW-1:0] rd_ptr, wr_ptr, rd_nx;
  logic [CW-1:0] count, remain;

  logic [31:0] pk_data;
  logic [3:0]  pk_be;
  logic        pk_ok, enq_ok, accept, push, pop;

  // Lane placement: replicate the narrow value across the word and let the
  // byte enables select the lanes that are actually written.
  always_comb begin
    pk_data = in_data;
    pk_be   = 4'b0000;
    pk_ok   = 1'b1;
    case (in_op)
      2'd0: pk_be = 4'b1111;
      2'd1: begin
        pk_data = {2{in_data[15:0]}};
        pk_be   = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        pk_data = {4{in_data[7:0]}};
        pk_be   = 4'b0001 << in_addr[1:0];
      end
      default: pk_ok = 1'b0;
    endcase
  end

`ifdef STORE_ALIGN_CHECK_EN
  logic misal;
  assign misal  = ((in_op == 2'd0) && (in_addr[1:0] != 2'b00)) ||
                  ((in_op == 2'd1) && in_addr[0]);
  assign enq_ok = pk_ok && !misal;
`else
  assign enq_ok = pk_ok;
`endif

  // No bypass: a full buffer refuses input even in a cycle that pops.
  assign in_ready  = !reset && (count < CW'(DEPTH));
  assign mem_valid = (count != '0);
  assign pending   = count;

  assign accept = in_valid && in_ready;
  assign push   = accept && enq_ok;
  assign pop    = mem_valid && mem_ready;
  assign rd_nx  = rd_ptr + AW'(pop);
  assign remain = count - CW'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
`ifdef STORE_ALIGN_CHECK_EN
      align_err <= 1'b0;
`endif
    end else begin
      if (push) begin
        q_addr[wr_ptr] <= in_addr[31:2];
        q_data[wr_ptr] <= pk_data;
        q_be[wr_ptr]   <= pk_be;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_nx;
      count  <= remain + CW'(push);

      // Head registers are loaded with whatever will be at the front next
      // cycle: an already-stored entry if one survives the pop, otherwise the
      // entry being pushed now. Empty keeps addr/data, clears enables.
      if (remain != '0) begin
        mem_addr  <= {q_addr[rd_nx], 2'b00};
        mem_wdata <= q_data[rd_nx];
        mem_be    <= q_be[rd_nx];
      end else if (push) begin
        mem_addr  <= {in_addr[31:2], 2'b00};
        mem_wdata <= pk_data;
        mem_be    <= pk_be;
      end else begin
        mem_be    <= 4'b0000;
      end
`ifdef STORE_ALIGN_CHECK_EN
      align_err <= accept && misal;
`endif
    end
  end

endmodule

// File: tb/tb_dm_store_packer.sv
// Bench for dm_store_packer: a queue-based model of the store buffer is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_dm_store_packer;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [1:0]  pending;
`ifdef STORE_ALIGN_CHECK_EN
  logic        align_err;
`endif

  dm_store_packer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_data(in_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .pending(pending)
`ifdef STORE_ALIGN_CHECK_EN
    , .align_err(align_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  bit   exp_align = 1'b0;

  // Spec-level packing with plain arithmetic.
  function automatic bit model_pack(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] d, output ent_t e);
    e.addr = a & 32'hFFFF_FFFC;
    e.wdata = d;
    e.be = 4'd0;
    case (op)
      2'd0: begin e.wdata = d; e.be = 4'd15; end
      2'd1: begin e.wdata = (d & 32'hFFFF) * 32'h0001_0001; e.be = ((a & 2) != 0) ? 4'd12 : 4'd3; end
      2'd2: begin e.wdata = (d & 32'hFF) * 32'h0101_0101; e.be = 4'(1 << (a % 4)); end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic bit model_misal(input logic [1:0] op, input logic [31:0] a);
`ifdef STORE_ALIGN_CHECK_EN
    return (op == 2'd0 && (a % 4) != 0) || (op == 2'd1 && (a % 2) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Compare, then advance the model to what the next rising edge produces.
  always @(negedge clk) begin
    ent_t e;
    bit acc, keep, pp;
    if (reset) begin
      chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < DEPTH)});
      chk("mem_valid", {31'd0, mem_valid}, {31'd0, (q.size() != 0)});
      chk("pending", {30'd0, pending}, 32'(q.size()));
      if (q.size() != 0) begin
        chk("mem_addr", mem_addr, q[0].addr);
        chk("mem_wdata", mem_wdata, q[0].wdata);
        chk("mem_be", {28'd0, mem_be}, {28'd0, q[0].be});
      end else begin
        chk("mem_be_empty", {28'd0, mem_be}, 32'd0);
      end
`ifdef STORE_ALIGN_CHECK_EN
      chk("align_err", {31'd0, align_err}, {31'd0, exp_align});
`endif
    end
    if (reset) begin
      q.delete();
      exp_align = 1'b0;
    end else begin
      acc = in_valid && (q.size() < DEPTH);
      pp  = (q.size() != 0) && mem_ready;
      keep = model_pack(in_op, in_addr, in_data, e);
      exp_align = acc && keep && model_misal(in_op, in_addr);
      if (pp) void'(q.pop_front());
      if (acc && keep && !model_misal(in_op, in_addr)) q.push_back(e);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drv(input logic v, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] d, input logic mr);
    in_valid = v; in_op = op; in_addr = a; in_data = d; mem_ready = mr;
  endtask

  typedef struct { logic [1:0] op; logic [31:0] a; logic [31:0] d; logic mr; } vec_t;
  vec_t tbl[10] = '{
    '{2'd2, 32'h0000_4000, 32'h0000_00A1, 1'b1},
    '{2'd2, 32'h0000_4001, 32'h0000_00B2, 1'b0},
    '{2'd1, 32'h0000_4000, 32'h1111_C3C3, 1'b0},
    '{2'd3, 32'h0000_4004, 32'hFFFF_FFFF, 1'b1},
    '{2'd2, 32'h0000_4002, 32'h0000_00D4, 1'b1},
    '{2'd0, 32'h0000_4008, 32'h0BAD_F00D, 1'b1},
    '{2'd1, 32'h0000_400E, 32'h0000_E5E5, 1'b0},
    '{2'd0, 32'h0000_400C, 32'h1234_0000, 1'b1},
    '{2'd2, 32'h0000_4003, 32'h0000_00F6, 1'b1},
    '{2'd1, 32'h0000_4012, 32'h0000_7777, 1'b1}
  };

  initial begin
    cyc(2);
    chk("reset_pending", {30'd0, pending}, 32'd0);
    chk("reset_mem_be", {28'd0, mem_be}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    cyc();

    // 1: SB to byte lane 3
    drv(1, 2'd2, 32'h0000_1003, 32'h1234_5678, 1);
    cyc();
    drv(0, 2'd0, 0, 0, 1);
    chk("t1_addr", mem_addr, 32'h0000_1000);
    chk("t1_be", {28'd0, mem_be}, 32'h8);
    chk("t1_wdata", mem_wdata, 32'h7878_7878);
    cyc();
    chk("t1_pending", {30'd0, pending}, 32'd0);

    // 2: SH upper half, then SW
    drv(1, 2'd1, 32'h0000_2002, 32'hAAAA_5555, 1);
    cyc();
    chk("t2_sh_be", {28'd0, mem_be}, 32'hC);
    chk("t2_sh_wdata", mem_wdata, 32'h5555_5555);
    drv(1, 2'd0, 32'h0000_3000, 32'hDEAD_BEEF, 1);
    cyc();
    drv(0, 2'd0, 0, 0, 1);
    chk("t2_sw_be", {28'd0, mem_be}, 32'hF);
    chk("t2_sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();

    // 3: fill while stalled, third store refused, drain in order
    drv(1, 2'd0, 32'h0000_0100, 32'hA000_0001, 0); cyc();
    drv(1, 2'd0, 32'h0000_0104, 32'hA000_0002, 0); cyc();
    chk("t3_pending_full", {30'd0, pending}, 32'd2);
    chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
    drv(1, 2'd0, 32'h0000_0108, 32'hA000_0003, 0); cyc();
    drv(0, 2'd0, 0, 0, 0); cyc(2);
    chk("t3_stall_wdata", mem_wdata, 32'hA000_0001);
    chk("t3_stall_addr", mem_addr, 32'h0000_0100);
    mem_ready = 1'b1; cyc();
    chk("t3_second", mem_wdata, 32'hA000_0002);
    cyc();
    chk("t3_drained", {30'd0, pending}, 32'd0);

    // 4: push and pop in the same cycle at pending=1, across pointer wrap
    drv(1, 2'd0, 32'h0000_0200, 32'hB000_0001, 0); cyc();
    drv(1, 2'd0, 32'h0000_0204, 32'hB000_0002, 1); cyc();
    chk("t4_pending", {30'd0, pending}, 32'd1);
    chk("t4_head", mem_wdata, 32'hB000_0002);
    drv(1, 2'd0, 32'h0000_0208, 32'hB000_0003, 1); cyc();
    chk("t4_pending_wrap", {30'd0, pending}, 32'd1);
    chk("t4_head_wrap", mem_wdata, 32'hB000_0003);
    drv(0, 2'd0, 0, 0, 1); cyc();

    // 5: misaligned SW
    drv(1, 2'd0, 32'h0000_1001, 32'hC0DE_0001, 0); cyc();
    drv(0, 2'd0, 0, 0, 0);
`ifdef STORE_ALIGN_CHECK_EN
    chk("t5_align_err", {31'd0, align_err}, 32'd1);
    chk("t5_pending", {30'd0, pending}, 32'd0);
    cyc();
    chk("t5_align_clr", {31'd0, align_err}, 32'd0);
`else
    chk("t5_addr", mem_addr, 32'h0000_1000);
    chk("t5_be", {28'd0, mem_be}, 32'hF);
    mem_ready = 1'b1; cyc();
`endif
    mem_ready = 1'b1; cyc();

    // mixed table, including reserved op
    foreach (tbl[i]) begin
      drv(1, tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].mr);
      cyc();
    end
    drv(0, 2'd0, 0, 0, 1); cyc(3);

    // 6: reset with two entries pending
    drv(1, 2'd0, 32'h0000_0300, 32'hD000_0001, 0); cyc();
    drv(1, 2'd0, 32'h0000_0304, 32'hD000_0002, 0); cyc();
    chk("t6_pending_pre", {30'd0, pending}, 32'd2);
    drv(0, 2'd0, 0, 0, 0);
    reset = 1'b1; cyc();
    chk("t6_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("t6_pending", {30'd0, pending}, 32'd0);
    chk("t6_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    reset = 1'b0; cyc();
    chk("t6_in_ready_rel", {31'd0, in_ready}, 32'd1);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
